// File: rtl/arb_pkg.sv
// Shared arbitration types and the rotate-priority search used by the round-robin arbiters.
// Purely combinational helpers; no latency, no backpressure.
package arb_pkg;

    localparam int ARB_MAX_W = 32;
    localparam int ARB_IDX_W = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 vld;
        logic [ARB_IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req[width-1:0] searching ptr, ptr+1, ... with wrap; ptr must be < width.
    function automatic pick_t rr_pick(input logic [ARB_MAX_W-1:0] req,
                                      input int unsigned width,
                                      input int unsigned ptr);
        pick_t       res;
        int unsigned j;
        res = '0;
        for (int unsigned i = 0; i < ARB_MAX_W; i++) begin
            j = ptr + i;
            if (j >= width) j = j - width;
            if (i < width && !res.vld && req[j[ARB_IDX_W-1:0]]) begin
                res.vld = 1'b1;
                res.idx = j[ARB_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotate-priority search over REQ_WIDTH request bits starting at ptr.
// Combinational, zero latency; no backpressure.
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int REQ_WIDTH = 8
) (
    input  logic [REQ_WIDTH-1:0]         req,
    input  logic [$clog2(REQ_WIDTH)-1:0] ptr,
    output logic [REQ_WIDTH-1:0]         onehot,
    output logic [$clog2(REQ_WIDTH)-1:0] idx,
    output logic                         vld
);

    localparam int IDX_W = $clog2(REQ_WIDTH);

    logic [ARB_MAX_W-1:0] req_ext;
    pick_t                pick;

    assign req_ext = ARB_MAX_W'(req);
    assign pick    = rr_pick(req_ext, REQ_WIDTH, 32'(ptr));
    assign vld     = pick.vld;
    assign idx     = IDX_W'(pick.idx);
    assign onehot  = pick.vld ? (REQ_WIDTH'(1) << idx) : '0;

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with multi-cycle ownership and MAX_HOLD preemption under contention.
// Grant registered one cycle after req; owner holds until done/req drop, handoff is bubble-free.
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int REQ_WIDTH = 8,
    parameter int MAX_HOLD  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [REQ_WIDTH-1:0]         req,
    input  logic [REQ_WIDTH-1:0]         done,
    output logic [REQ_WIDTH-1:0]         gnt,
    output logic [$clog2(REQ_WIDTH)-1:0] gnt_id,
    output logic                         busy,
    output logic                         preempt
);

    localparam int IDX_W     = $clog2(REQ_WIDTH);
    localparam int CNT_W     = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int CNT_MAX_I = (MAX_HOLD < 1) ? 0 : MAX_HOLD - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MAX_I);

    arb_state_t           state;
    logic [IDX_W-1:0]     ptr;
    logic [CNT_W-1:0]     hold_cnt;

    logic                 own_req;
    logic                 own_done;
    logic [REQ_WIDTH-1:0] others;
    logic                 release_req;
    logic                 expire;
    logic [IDX_W-1:0]     ptr_after;
    logic [REQ_WIDTH-1:0] pick_req;
    logic [IDX_W-1:0]     pick_ptr;
    logic [REQ_WIDTH-1:0] pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;

    assign own_req     = req[gnt_id];
    assign own_done    = done[gnt_id];
    assign others      = req & ~gnt;
    assign release_req = (state == HOLD) && (own_done || !own_req);
    // Expiry only matters if someone else is waiting; a normal release takes precedence.
    assign expire      = (state == HOLD) && (MAX_HOLD != 0) && (hold_cnt == CNT_MAX)
                         && !release_req && (|others);
    assign ptr_after   = (gnt_id == IDX_W'(REQ_WIDTH - 1)) ? '0 : gnt_id + 1'b1;

    // In HOLD the search excludes the outgoing owner so it ends up last in priority.
    assign pick_req    = (state == HOLD) ? others : req;
    assign pick_ptr    = (state == HOLD) ? ptr_after : ptr;

    rr_priority_pick #(
        .REQ_WIDTH(REQ_WIDTH)
    ) u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .onehot(pick_onehot),
        .idx   (pick_idx),
        .vld   (pick_vld)
    );

    assign busy = |gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            preempt  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    preempt <= 1'b0;
                    if (pick_vld) begin
                        gnt      <= pick_onehot;
                        gnt_id   <= pick_idx;
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (release_req || expire) begin
                        ptr     <= ptr_after;
                        preempt <= expire;
                        if (pick_vld) begin
                            gnt      <= pick_onehot;
                            gnt_id   <= pick_idx;
                            hold_cnt <= '0;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        preempt <= 1'b0;
                        if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
